sc_position_counter_ud: RTL and testbench

SC_POSITION_COUNTER_UD -- requirements
Module: sc_position_counter_ud

---
 rtl/sc_position_pkg.sv | 23 ++
 rtl/sc_position_repeat_timer.sv | 38 +++
 rtl/sc_position_counter_ud.sv | 158 +++++++++++++++
 tb/tb_sc_position_counter_ud.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/sc_position_pkg.sv
// Shared types and helpers for the up/down position counter.
package sc_position_pkg;

    // Button-hold FSM states.
    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StHoldUp   = 2'd1,
        StHoldDown = 2'd2
    } posState_e;

    // Boundary behaviour selected by the WRAP parameter.
    localparam int unsigned WrapSaturate = 0;
    localparam int unsigned WrapAround   = 1;

    // Bits needed to count 0 .. repeatPeriod-1; never narrower than one bit.
    function automatic int unsigned repeatCntWidth(input int unsigned repeatPeriod);
        if (repeatPeriod <= 2) begin
            return 1;
        end
        return $clog2(repeatPeriod);
    endfunction

endpackage

// File: rtl/sc_position_repeat_timer.sv
// Auto-repeat timer: counts clocks while a button is held and ticks once
// every REPEAT clocks. REPEAT = 0 disables ticking altogether.
module sc_position_repeat_timer
    import sc_position_pkg::*;
#(
    parameter int unsigned REPEAT = 25000000
) (
    input  logic clock,
    input  logic reset,
    input  logic run,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CntWidth = repeatCntWidth(REPEAT);
    localparam logic [CntWidth-1:0] LastCount = CntWidth'((REPEAT == 0) ? 0 : REPEAT - 1);
    localparam bit Enabled = (REPEAT != 0);

    logic [CntWidth-1:0] countReg;
    logic                atLast;

    assign atLast = (countReg == LastCount);

    // Tick is combinational so the step lands on the same edge the count wraps.
    assign tick = Enabled && run && !clear && atLast;

    // Repeat counter: clear has priority, wraps to 0 on each tick.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            countReg <= '0;
        end else if (clear || !Enabled) begin
            countReg <= '0;
        end else if (run) begin
            countReg <= atLast ? '0 : countReg + CntWidth'(1);
        end
    end

endmodule

// File: rtl/sc_position_counter_ud.sv
// Up/down position counter driven by active-low buttons, with press-edge
// stepping, hold-to-repeat, synchronous restart and saturate/wrap bounds.
module sc_position_counter_ud
    import sc_position_pkg::*;
#(
    parameter int unsigned DATAWIDTH = 3,
    parameter int unsigned MIN       = 0,
    parameter int unsigned MAX       = 7,
    parameter int unsigned START     = 0,
    parameter int unsigned WRAP      = 0,
    parameter int unsigned REPEAT    = 25000000
) (
    input  logic                 SC_positionYCOUNTER_CLOCK_50,
    input  logic                 SC_positionYCOUNTER_RESET_InHigh,
    input  logic                 up_InLow,
    input  logic                 down_InLow,
    input  logic                 restart_InLow,
    output logic [DATAWIDTH-1:0] data_OutBUS,
    output logic                 atMin_Out,
    output logic                 atMax_Out,
    output logic                 goal_Out
);

    localparam logic [DATAWIDTH-1:0] MinPos   = DATAWIDTH'(MIN);
    localparam logic [DATAWIDTH-1:0] MaxPos   = DATAWIDTH'(MAX);
    localparam logic [DATAWIDTH-1:0] StartPos = DATAWIDTH'(START);

    posState_e            state;
    logic [DATAWIDTH-1:0] position;
    logic [DATAWIDTH-1:0] posNext;
    logic                 upPrev;
    logic                 downPrev;
    logic                 upPress;
    logic                 downPress;
    logic                 bothLow;
    logic                 restartReq;
    logic                 holding;
    logic                 timerRun;
    logic                 timerClear;
    logic                 tick;
    logic                 doUp;
    logic                 doDown;
    logic                 goalNext;

    // One step up; at MAX either hold or wrap to MIN, never past MAX.
    function automatic logic [DATAWIDTH-1:0] incPos(input logic [DATAWIDTH-1:0] pos);
        if (pos == MaxPos) begin
            return (WRAP == WrapAround) ? MinPos : MaxPos;
        end
        return pos + DATAWIDTH'(1);
    endfunction

    // One step down; at MIN either hold or wrap to MAX, never below MIN.
    function automatic logic [DATAWIDTH-1:0] decPos(input logic [DATAWIDTH-1:0] pos);
        if (pos == MinPos) begin
            return (WRAP == WrapAround) ? MaxPos : MinPos;
        end
        return pos - DATAWIDTH'(1);
    endfunction

    // Button event decode and repeat-timer control.
    always_comb begin
        upPress    = upPrev && !up_InLow;
        downPress  = downPrev && !down_InLow;
        bothLow    = !up_InLow && !down_InLow;
        restartReq = !restart_InLow;
        // Only a single held button in its matching hold state keeps the timer running.
        holding    = ((state == StHoldUp) && !up_InLow && down_InLow) ||
                     ((state == StHoldDown) && !down_InLow && up_InLow);
        timerRun   = holding && !restartReq;
        timerClear = !timerRun;
    end

    sc_position_repeat_timer #(
        .REPEAT (REPEAT)
    ) uRepeatTimer (
        .clock (SC_positionYCOUNTER_CLOCK_50),
        .reset (SC_positionYCOUNTER_RESET_InHigh),
        .run   (timerRun),
        .clear (timerClear),
        .tick  (tick)
    );

    // Step selection and next position; restart beats everything.
    always_comb begin
        doUp   = 1'b0;
        doDown = 1'b0;
        if (!restartReq && !bothLow) begin
            if (upPress) begin
                doUp = 1'b1;
            end else if (downPress) begin
                doDown = 1'b1;
            end else if (tick) begin
                // tick only fires in a hold state, so state names the direction
                doUp   = (state == StHoldUp);
                doDown = (state == StHoldDown);
            end
        end

        if (restartReq) begin
            posNext = StartPos;
        end else if (doUp) begin
            posNext = incPos(position);
        end else if (doDown) begin
            posNext = decPos(position);
        end else begin
            posNext = position;
        end

        goalNext = doUp && (position == MaxPos);
    end

    // FSM, position, button history and registered flag outputs.
    always_ff @(posedge SC_positionYCOUNTER_CLOCK_50 or posedge SC_positionYCOUNTER_RESET_InHigh) begin
        if (SC_positionYCOUNTER_RESET_InHigh) begin
            state     <= StIdle;
            position  <= StartPos;
            atMin_Out <= (StartPos == MinPos);
            atMax_Out <= (StartPos == MaxPos);
            goal_Out  <= 1'b0;
            // History starts as "pressed" so a button held through reset is ignored.
            upPrev    <= 1'b0;
            downPrev  <= 1'b0;
        end else begin
            upPrev    <= up_InLow;
            downPrev  <= down_InLow;
            position  <= posNext;
            atMin_Out <= (posNext == MinPos);
            atMax_Out <= (posNext == MaxPos);
            goal_Out  <= goalNext;

            if (restartReq || bothLow) begin
                state <= StIdle;
            end else if (upPress) begin
                state <= StHoldUp;
            end else if (downPress) begin
                state <= StHoldDown;
            end else begin
                case (state)
                    StHoldUp: begin
                        if (up_InLow) begin
                            state <= StIdle;
                        end
                    end
                    StHoldDown: begin
                        if (down_InLow) begin
                            state <= StIdle;
                        end
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

    assign data_OutBUS = position;

endmodule

// File: tb/tb_sc_position_counter_ud.sv
// Directed bench for sc_position_counter_ud: a saturating and a wrapping
// instance share stimulus; expected values go through a scoreboard queue.
module tb_sc_position_counter_ud;
    import sc_position_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       up;
    logic       down;
    logic       restart;
    logic [2:0] dataSat;
    logic [2:0] dataWrap;
    logic       atMinSat;
    logic       atMaxSat;
    logic       goalSat;
    logic       atMinWrap;
    logic       atMaxWrap;
    logic       goalWrap;

    typedef struct packed {
        logic [2:0] sat;
        logic [2:0] wrp;
        logic       goalSat;
        logic       goalWrap;
    } exp_t;

    exp_t  expQ[$];
    string tagQ[$];
    int    nCompared = 0;
    int    nMismatch = 0;

    always #5 clk = ~clk;

    sc_position_counter_ud #(
        .DATAWIDTH (3), .MIN (0), .MAX (7), .START (0), .WRAP (0), .REPEAT (4)
    ) dutSat (
        .SC_positionYCOUNTER_CLOCK_50     (clk),
        .SC_positionYCOUNTER_RESET_InHigh (rst),
        .up_InLow                         (up),
        .down_InLow                       (down),
        .restart_InLow                    (restart),
        .data_OutBUS                      (dataSat),
        .atMin_Out                        (atMinSat),
        .atMax_Out                        (atMaxSat),
        .goal_Out                         (goalSat)
    );

    sc_position_counter_ud #(
        .DATAWIDTH (3), .MIN (0), .MAX (7), .START (0), .WRAP (1), .REPEAT (4)
    ) dutWrap (
        .SC_positionYCOUNTER_CLOCK_50     (clk),
        .SC_positionYCOUNTER_RESET_InHigh (rst),
        .up_InLow                         (up),
        .down_InLow                       (down),
        .restart_InLow                    (restart),
        .data_OutBUS                      (dataWrap),
        .atMin_Out                        (atMinWrap),
        .atMax_Out                        (atMaxWrap),
        .goal_Out                         (goalWrap)
    );

    task automatic pushExp(input logic [2:0] eS, input logic [2:0] eW,
                           input logic gS, input logic gW, input string t);
        exp_t x;
        x.sat      = eS;
        x.wrp      = eW;
        x.goalSat  = gS;
        x.goalWrap = gW;
        expQ.push_back(x);
        tagQ.push_back(t);
    endtask

    // Pop one expectation and compare {data, atMin, atMax, goal} of both DUTs.
    task automatic checkOut();
        exp_t       e;
        string      t;
        logic [5:0] obsS;
        logic [5:0] expS;
        logic [5:0] obsW;
        logic [5:0] expW;
        nCompared++;
        assert (expQ.size() > 0) else begin
            nMismatch++;
            $error("FAIL scoreboard-empty observed=%0d required>0", expQ.size());
        end
        if (expQ.size() > 0) begin
            e    = expQ.pop_front();
            t    = tagQ.pop_front();
            obsS = {dataSat, atMinSat, atMaxSat, goalSat};
            expS = {e.sat, e.sat == 3'd0, e.sat == 3'd7, e.goalSat};
            obsW = {dataWrap, atMinWrap, atMaxWrap, goalWrap};
            expW = {e.wrp, e.wrp == 3'd0, e.wrp == 3'd7, e.goalWrap};
            assert (obsS === expS) else begin
                nMismatch++;
                $error("FAIL %s (sat) data/min/max/goal observed=%b required=%b", t, obsS, expS);
            end
            nCompared++;
            assert (obsW === expW) else begin
                nMismatch++;
                $error("FAIL %s (wrap) data/min/max/goal observed=%b required=%b", t, obsW, expW);
            end
        end
    endtask

    // Drive one cycle of buttons, then check outputs just after the edge.
    task automatic cyc(input logic u, input logic d, input logic r,
                       input logic [2:0] eS, input logic [2:0] eW,
                       input logic gS, input logic gW, input string t);
        up      = u;
        down    = d;
        restart = r;
        pushExp(eS, eW, gS, gW, t);
        @(posedge clk);
        #1;
        checkOut();
    endtask

    task automatic checkIdle(input string t);
        nCompared++;
        assert (dutSat.state === StIdle && dutWrap.state === StIdle) else begin
            nMismatch++;
            $error("FAIL %s state observed=%0d/%0d required=%0d", t, dutSat.state,
                   dutWrap.state, StIdle);
        end
    endtask

    initial begin
        int e;
        rst     = 1'b1;
        up      = 1'b1;
        down    = 1'b1;
        restart = 1'b1;
        #2;
        pushExp(3'd0, 3'd0, 1'b0, 1'b0, "reset state");
        checkOut();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(1, 1, 1, 3'd0, 3'd0, 0, 0, "idle after reset");

        // Single presses walk up to MAX; no goal on the way.
        for (int i = 1; i <= 7; i++) begin
            cyc(0, 1, 1, 3'(i), 3'(i), 0, 0, $sformatf("up press %0d", i));
            cyc(1, 1, 1, 3'(i), 3'(i), 0, 0, $sformatf("up release %0d", i));
        end
        cyc(0, 1, 1, 3'd7, 3'd0, 1, 1, "up at max");
        cyc(1, 1, 1, 3'd7, 3'd0, 0, 0, "goal one clock");
        cyc(1, 0, 1, 3'd6, 3'd7, 0, 0, "down press from max/min");
        cyc(1, 1, 1, 3'd6, 3'd7, 0, 0, "down release");
        cyc(1, 1, 0, 3'd0, 3'd0, 0, 0, "restart");
        cyc(1, 1, 1, 3'd0, 3'd0, 0, 0, "after restart");
        cyc(1, 0, 1, 3'd0, 3'd7, 0, 0, "down at min");
        cyc(1, 1, 1, 3'd0, 3'd7, 0, 0, "down release at min");
        cyc(1, 1, 0, 3'd0, 3'd0, 0, 0, "restart again");
        cyc(1, 1, 1, 3'd0, 3'd0, 0, 0, "after restart again");

        // Hold up: step at press, then every 4 clocks up to 5.
        cyc(0, 1, 1, 3'd1, 3'd1, 0, 0, "hold up press");
        for (int k = 1; k <= 16; k++) begin
            e = 1 + k / 4;
            cyc(0, 1, 1, 3'(e), 3'(e), 0, 0, $sformatf("hold up clk %0d", k));
        end
        cyc(1, 1, 1, 3'd5, 3'd5, 0, 0, "hold up release");

        // Hold down from 5 for 10 clocks.
        cyc(1, 0, 1, 3'd4, 3'd4, 0, 0, "hold down press");
        for (int k = 1; k <= 9; k++) begin
            e = 4 - k / 4;
            cyc(1, 0, 1, 3'(e), 3'(e), 0, 0, $sformatf("hold down clk %0d", k));
        end
        cyc(1, 1, 1, 3'd2, 3'd2, 0, 0, "hold down release");
        checkIdle("idle after down release");

        // Both buttons low together: no step, timer idle.
        cyc(0, 1, 1, 3'd3, 3'd3, 0, 0, "up to 3");
        cyc(1, 1, 1, 3'd3, 3'd3, 0, 0, "release at 3");
        for (int k = 0; k < 6; k++) begin
            cyc(0, 0, 1, 3'd3, 3'd3, 0, 0, $sformatf("both low %0d", k));
        end
        nCompared++;
        assert (dutSat.uRepeatTimer.countReg === 2'd0) else begin
            nMismatch++;
            $error("FAIL both-low repeat count observed=%0d required=0",
                   dutSat.uRepeatTimer.countReg);
        end
        checkIdle("idle while both low");
        cyc(1, 0, 1, 3'd3, 3'd3, 0, 0, "down still held");
        cyc(1, 1, 1, 3'd3, 3'd3, 0, 0, "both released");

        // Restart while holding up aborts the repeat.
        cyc(0, 1, 1, 3'd4, 3'd4, 0, 0, "press before restart");
        cyc(0, 1, 1, 3'd4, 3'd4, 0, 0, "hold before restart 1");
        cyc(0, 1, 1, 3'd4, 3'd4, 0, 0, "hold before restart 2");
        cyc(0, 1, 0, 3'd0, 3'd0, 0, 0, "restart mid-hold");
        for (int k = 0; k < 6; k++) begin
            cyc(0, 1, 1, 3'd0, 3'd0, 0, 0, $sformatf("held after restart %0d", k));
        end
        cyc(1, 1, 1, 3'd0, 3'd0, 0, 0, "release after restart");

        // Asynchronous reset mid-hold, button kept low through it.
        cyc(0, 1, 1, 3'd1, 3'd1, 0, 0, "press before reset");
        cyc(0, 1, 1, 3'd1, 3'd1, 0, 0, "hold before reset 1");
        cyc(0, 1, 1, 3'd1, 3'd1, 0, 0, "hold before reset 2");
        #2;
        rst = 1'b1;
        #1;
        pushExp(3'd0, 3'd0, 1'b0, 1'b0, "async reset mid-hold");
        checkOut();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            cyc(0, 1, 1, 3'd0, 3'd0, 0, 0, $sformatf("held after reset %0d", k));
        end
        cyc(1, 1, 1, 3'd0, 3'd0, 0, 0, "release after reset");
        cyc(0, 1, 1, 3'd1, 3'd1, 0, 0, "re-press after reset");
        cyc(1, 1, 1, 3'd1, 3'd1, 0, 0, "final release");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
